// File: rtl/trivium_stream_p.sv
// Trivium stream-cipher engine with a W-bit datapath and valid/ready data sides.
// Optional build macro TRIV_IV_AUTOINC_EN: on expiry, reload with the stored key and IV+1 and re-initialise.
module trivium_stream_p #(
  parameter int          W          = 8,
  parameter int unsigned MAX_BEATS  = 256,
  parameter int          INIT_STEPS = 1152 / W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_load,
  input  logic [79:0]   key,
  input  logic [79:0]   iv,
  input  logic [W-1:0]  din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic [W-1:0]  dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [1:0]    state_o,
  output logic          rekey_req
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_INIT = 2'b01,
    S_RUN  = 2'b10,
    S_EXP  = 2'b11
  } state_t;

  localparam int             ICW       = $clog2(INIT_STEPS + 1);
  localparam logic [ICW-1:0] INIT_LAST = ICW'(INIT_STEPS - 1);
  localparam logic [31:0]    BEAT_LAST = 32'(MAX_BEATS - 1);

  state_t         state, state_nxt;
  logic [287:0]   s;
  logic [287:0]   s_step;
  logic [287:0]   s_tmp;
  logic [W-1:0]   ks;
  logic [ICW-1:0] init_cnt;
  logic [31:0]    beat_cnt;
  logic           accept;
  logic           last_init;
  logic           last_beat;
  logic           auto_reload;

  // Bit i of the vector holds Trivium state bit s(i+1).
  function automatic logic [287:0] load_state(input logic [79:0] k, input logic [79:0] v);
    logic [287:0] r;
    r          = '0;
    r[79:0]    = k;
    r[172:93]  = v;
    r[287:285] = 3'b111;
    return r;
  endfunction

  // One bit-update: returns {z, next_state}.
  function automatic logic [288:0] step1(input logic [287:0] st);
    logic t1, t2, t3, z;
    t1 = st[65]  ^ st[92];
    t2 = st[161] ^ st[176];
    t3 = st[242] ^ st[287];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (st[90]  & st[91])  ^ st[170];
    t2 = t2 ^ (st[174] & st[175]) ^ st[263];
    t3 = t3 ^ (st[285] & st[286]) ^ st[68];
    return {z, st[286:177], t2, st[175:93], t1, st[91:0], t3};
  endfunction

  // W chained updates; ks[0] is the earliest keystream bit.
  always_comb begin
    logic [288:0] r;
    s_tmp = s;
    ks    = '0;
    r     = '0;
    for (int i = 0; i < W; i++) begin
      r     = step1(s_tmp);
      ks[i] = r[288];
      s_tmp = r[287:0];
    end
    s_step = s_tmp;
  end

  assign din_ready = (state == S_RUN) && !key_load && (!dout_valid || dout_ready);
  assign accept    = din_valid && din_ready;
  assign last_init = (state == S_INIT) && (init_cnt == INIT_LAST);
  assign last_beat = accept && (beat_cnt == BEAT_LAST);
  assign state_o   = state;
  assign rekey_req = (state == S_EXP);

`ifdef TRIV_IV_AUTOINC_EN
  logic [79:0] key_q;
  logic [79:0] iv_q;
  assign auto_reload = (state == S_EXP);
`else
  assign auto_reload = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (key_load) begin
      state_nxt = S_INIT;
    end else begin
      case (state)
        S_INIT:  if (last_init)   state_nxt = S_RUN;
        S_RUN:   if (last_beat)   state_nxt = S_EXP;
        S_EXP:   if (auto_reload) state_nxt = S_INIT;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s          <= '0;
      init_cnt   <= '0;
      beat_cnt   <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
`ifdef TRIV_IV_AUTOINC_EN
      key_q      <= '0;
      iv_q       <= '0;
`endif
    end else if (key_load) begin
      s          <= load_state(key, iv);
      init_cnt   <= '0;
      beat_cnt   <= '0;
      dout_valid <= 1'b0;
`ifdef TRIV_IV_AUTOINC_EN
      key_q      <= key;
      iv_q       <= iv;
`endif
    end else begin
`ifdef TRIV_IV_AUTOINC_EN
      if (auto_reload) begin
        s        <= load_state(key_q, iv_q + 80'd1);
        iv_q     <= iv_q + 80'd1;
        init_cnt <= '0;
        beat_cnt <= '0;
      end
`endif
      if (state == S_INIT) begin
        s        <= s_step;
        init_cnt <= init_cnt + ICW'(1);
      end
      // A pending output keeps draining regardless of state.
      if (accept) begin
        s          <= s_step;
        dout       <= din ^ ks;
        dout_valid <= 1'b1;
        beat_cnt   <= beat_cnt + 32'd1;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trivium_stream_p.sv
// Bench for trivium_stream_p: W=8 engine against a bit-serial reference model, plus a W=1 engine.
module tb_trivium_stream_p;

  localparam int MB = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_load;
  logic [79:0] key, iv;
  logic [7:0]  din, dout;
  logic        din_valid, din_ready, dout_valid, dout_ready, rekey_req;
  logic [1:0]  state_o;

  logic [0:0]  w1_din, w1_dout;
  logic        w1_din_valid, w1_din_ready, w1_dout_valid, w1_dout_ready, w1_rekey;
  logic [1:0]  w1_state;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  cap_q[$];
  bit          capture = 0;
  int          rdy_mode = 0;
  int          rdy_phase = 0;
  logic [3:0]  rdy_pat = 4'b1001;
  logic        m_s [1:288];

  always #5 clk = ~clk;

  trivium_stream_p #(.W(8), .MAX_BEATS(MB)) u_dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key(key), .iv(iv),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .state_o(state_o), .rekey_req(rekey_req)
  );

  trivium_stream_p #(.W(1), .MAX_BEATS(1024)) u_w1 (
    .clk(clk), .rst(rst), .key_load(key_load), .key(key), .iv(iv),
    .din(w1_din), .din_valid(w1_din_valid), .din_ready(w1_din_ready),
    .dout(w1_dout), .dout_valid(w1_dout_valid), .dout_ready(w1_dout_ready),
    .state_o(w1_state), .rekey_req(w1_rekey)
  );

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference model, one bit-update at a time on a 1-based state array.
  task automatic model_load(input logic [79:0] k, input logic [79:0] v);
    for (int i = 1; i <= 288; i++) m_s[i] = 1'b0;
    for (int i = 0; i < 80; i++) begin
      m_s[i+1]  = k[i];
      m_s[94+i] = v[i];
    end
    m_s[286] = 1'b1; m_s[287] = 1'b1; m_s[288] = 1'b1;
  endtask

  task automatic model_bit(output logic z);
    logic t1, t2, t3;
    t1 = m_s[66]  ^ m_s[93];
    t2 = m_s[162] ^ m_s[177];
    t3 = m_s[243] ^ m_s[288];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (m_s[91]  & m_s[92])  ^ m_s[171];
    t2 = t2 ^ (m_s[175] & m_s[176]) ^ m_s[264];
    t3 = t3 ^ (m_s[286] & m_s[287]) ^ m_s[69];
    for (int i = 288; i > 1; i--) m_s[i] = m_s[i-1];
    m_s[1] = t3; m_s[94] = t1; m_s[178] = t2;
  endtask

  task automatic model_byte(output logic [7:0] b);
    logic zb;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      model_bit(zb);
      b[i] = zb;
    end
  endtask

  task automatic model_init();
    logic zb;
    for (int i = 0; i < 1152; i++) model_bit(zb);
  endtask

  // Driver: holds the beat until accepted; pushes the expected output on acceptance.
  task automatic send_beat(input logic [7:0] d, input logic [7:0] e, input int budget, output bit ok);
    ok = 0;
    din = d;
    din_valid = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (din_ready) begin
        exp_q.push_back(e);
        ok = 1;
        @(negedge clk); #2;
        break;
      end
      @(negedge clk); #2;
    end
  endtask

  task automatic wait_state(input logic [1:0] st, input int budget, input string name);
    for (int c = 0; c < budget; c++) begin
      if (state_o == st) break;
      @(negedge clk); #2;
    end
    check(name, state_o, st);
  endtask

  task automatic drain(input int budget, input string name);
    for (int c = 0; c < budget; c++) begin
      if (exp_q.size() == 0 && !dout_valid) break;
      @(negedge clk); #2;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic pulse_key_load();
    key_load = 1'b1;
    @(negedge clk); #2;
    key_load = 1'b0;
  endtask

  // Monitor: drives dout_ready, pops the scoreboard on each output transfer, checks stall stability.
  initial begin
    logic       hold_valid;
    logic [7:0] hold_val;
    hold_valid = 1'b0;
    hold_val   = '0;
    dout_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0: dout_ready = 1'b1;
        1: begin
          dout_ready = rdy_pat[rdy_phase];
          rdy_phase  = (rdy_phase + 1) % 4;
        end
        2: dout_ready = 1'($urandom_range(0, 1));
        default: dout_ready = 1'b0;
      endcase
      #1;
      if (!rst) begin
        hold_valid = 1'b0;
      end else begin
        if (hold_valid && dout_valid) check("dout_hold", dout, hold_val);
        if (dout_valid && dout_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL dout_unexpected: got %0h, expected no output", dout);
          end else begin
            check("dout", dout, exp_q.pop_front());
          end
          if (capture) cap_q.push_back(dout);
        end
        hold_valid = dout_valid && !dout_ready;
        hold_val   = dout;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [79:0] k1, iv1;
    logic [7:0]  pt [16];
    logic [7:0]  ks8 [64];
    logic [7:0]  e, d, wb;
    bit          ok, early;
    int          n_init, n_acc, nbits, nbytes;

    k1  = 80'h3A5F_9C01_77E2_B4D8_1E60;
    iv1 = 80'hC0FF_EE12_3456_789A_BCDE;
    rst = 1'b0; key_load = 1'b0; key = '0; iv = '0;
    din = '0; din_valid = 1'b0;
    w1_din = '0; w1_din_valid = 1'b0; w1_dout_ready = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    #2;
    check("rst_state", state_o, 2'b00);
    check("rst_dout_valid", dout_valid, 1'b0);
    check("rst_dout", dout, 8'h00);
    check("rst_rekey", rekey_req, 1'b0);
    check("rst_din_ready", din_ready, 1'b0);
    rst = 1'b1;
    @(negedge clk); #2;

    // IDLE refuses data
    din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("idle_din_ready", din_ready, 1'b0);
      check("idle_state", state_o, 2'b00);
      @(negedge clk); #2;
    end

    // Initialisation timing: 144 INIT cycles, then ready
    key = k1; iv = iv1;
    pulse_key_load();
    n_init = 0; early = 0;
    while (state_o == 2'b01 && n_init < 400) begin
      if (din_ready) early = 1;
      n_init++;
      @(negedge clk); #2;
    end
    check("init_cycles", n_init, 144);
    check("init_ready_low", early, 0);
    check("run_state", state_o, 2'b10);
    check("first_ready", din_ready, 1'b1);
    din_valid = 1'b0;
    model_load(k1, iv1);
    model_init();

    // Encrypt 16 bytes with random downstream backpressure
    rdy_mode = 2;
    capture  = 1;
    for (int i = 0; i < 16; i++) begin
      pt[i] = 8'($urandom_range(0, 255));
      model_byte(e);
      send_beat(pt[i], pt[i] ^ e, 40, ok);
      check("enc_accept", ok, 1'b1);
    end
    din_valid = 1'b0;
    drain(100, "enc_drain");
    capture = 0;
    check("enc_count", cap_q.size(), 16);

    // Reload the same key/IV from RUN and decrypt the captured ciphertext
    pulse_key_load();
    wait_state(2'b10, 300, "dec_run");
    rdy_mode = 0;
    for (int i = 0; i < 16; i++) begin
      d = (i < cap_q.size()) ? cap_q[i] : 8'h00;
      send_beat(d, pt[i], 20, ok);
      check("dec_accept", ok, 1'b1);
    end
    din_valid = 1'b0;
    drain(50, "dec_drain");

    // Restart while an output is stalled: pending beat discarded, key_load blocks din
    rdy_mode = 3;
    send_beat(8'h5A, 8'h00, 20, ok);
    check("stall_accept", ok, 1'b1);
    check("stall_valid", dout_valid, 1'b1);
    key_load = 1'b1;
    #1;
    check("kl_priority", din_ready, 1'b0);
    @(negedge clk); #2;
    key_load  = 1'b0;
    din_valid = 1'b0;
    check("restart_valid", dout_valid, 1'b0);
    check("restart_state", state_o, 2'b01);
    exp_q.delete();
    rdy_mode = 0;
    model_load(k1, iv1);
    model_init();
    wait_state(2'b10, 300, "restart_run");

    // Expiry: beat counter restarted, so exactly MB beats pass with ready pattern 1,0,0,1
    rdy_mode = 1; rdy_phase = 0;
    n_acc = 0;
    for (int i = 0; i < MB + 3; i++) begin
      d = 8'($urandom_range(0, 255));
      model_byte(e);
      send_beat(d, d ^ e, 12, ok);
      if (ok) n_acc++;
    end
    check("expire_beats", n_acc, MB);
    check("expire_state", state_o, 2'b11);
    check("expire_rekey", rekey_req, 1'b1);
    check("expire_din_ready", din_ready, 1'b0);
    din_valid = 1'b0;
    drain(20, "expire_drain");
    check("expire_hold_state", state_o, 2'b11);

    // W=1 vs W=8 keystream equivalence for 64 bytes, din=0
    key = 80'h0123456789ABCDEF0123; iv = 80'h0;
    pulse_key_load();
    model_load(key, iv);
    model_init();
    for (int i = 0; i < 64; i++) model_byte(ks8[i]);
    rdy_mode = 0;
    wait_state(2'b10, 300, "eq_run8");
    for (int i = 0; i < 64; i++) begin
      send_beat(8'h00, ks8[i], 20, ok);
      check("eq_accept8", ok, 1'b1);
    end
    din_valid = 1'b0;
    drain(20, "eq_drain8");
    w1_din_valid = 1'b1; w1_dout_ready = 1'b1;
    nbits = 0; nbytes = 0; wb = '0;
    for (int c = 0; c < 2000 && nbytes < 64; c++) begin
      if (w1_dout_valid) begin
        wb[nbits] = w1_dout[0];
        nbits++;
        if (nbits == 8) begin
          check("eq_w1_byte", wb, ks8[nbytes]);
          nbytes++;
          nbits = 0;
        end
      end
      @(negedge clk); #2;
    end
    check("eq_w1_count", nbytes, 64);
    w1_din_valid = 1'b0;

    // Asynchronous reset mid-INIT
    pulse_key_load();
    repeat (10) @(negedge clk);
    #2;
    check("midinit_state", state_o, 2'b01);
    #1;
    rst = 1'b0;
    #1;
    check("arst_state", state_o, 2'b00);
    check("arst_w1_state", w1_state, 2'b00);
    check("arst_din_ready", din_ready, 1'b0);
    check("arst_dout_valid", dout_valid, 1'b0);
    check("arst_rekey", rekey_req, 1'b0);
    @(negedge clk); #2;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    check("post_rst_idle", state_o, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
